// File: rtl/pulse_param_scheduler.sv
// Pulse parameter scheduler: queues validated {Ton, Ts, Id, repeat} sets from a host and
// applies them to a buck controller one at a time, switching sets only on pulse boundaries.
module pulse_param_scheduler #(
  parameter int unsigned DEPTH     = 4,
  parameter logic [15:0] TS_MIN    = 16'd100,
  parameter logic [15:0] DEAD_TIME = 16'd5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        clr_fault,
  input  logic        fault,
  input  logic        pulse_end,
  input  logic        cfg_valid,
  output logic        cfg_ready,
  input  logic [15:0] cfg_ton,
  input  logic [15:0] cfg_ts,
  input  logic [15:0] cfg_id,
  input  logic [15:0] cfg_repeat,
  output logic        power_start,
  output logic [15:0] Ton,
  output logic [15:0] Ts,
  output logic [15:0] Id_set,
  output logic        set_active,
  output logic [15:0] pulse_cnt,
  output logic        cfg_err,
  output logic        fault_latched
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam logic [PtrW-1:0] PtrMax  = PtrW'(DEPTH - 1);
  localparam logic [CntW-1:0] CntFull = CntW'(DEPTH);

  typedef enum logic [1:0] {StIdle, StRun, StStop, StFault} state_e;

  typedef struct packed {
    logic [15:0] ton;
    logic [15:0] ts;
    logic [15:0] id;
    logic [15:0] rpt;
  } set_t;

  state_e          state_q, state_d;
  set_t            mem_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;

  logic [15:0] ton_q, ton_d;
  logic [15:0] ts_q, ts_d;
  logic [15:0] id_q, id_d;
  logic [15:0] rpt_q, rpt_d;
  logic [15:0] cnt_q, cnt_d;
  logic        power_start_q, set_active_q, cfg_err_q, fault_latched_q;

  set_t        head;
  set_t        in_set;
  logic [16:0] ts_ext;
  logic [16:0] ton_guard;
  logic [16:0] cnt_inc;
  logic        set_ok;
  logic        hs;
  logic        push;
  logic        pop;
  logic        flush;
  logic        set_done;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrMax) ? '0 : p + 1'b1;
  endfunction

  // Set validation; both checks in 17 bits so Ton plus the dead-time margin cannot wrap.
  assign ts_ext    = {1'b0, cfg_ts};
  assign ton_guard = {1'b0, cfg_ton} + {DEAD_TIME, 1'b0};
  assign set_ok    = (ts_ext >= {1'b0, TS_MIN}) && (ton_guard < ts_ext);

  assign cfg_ready = (count_q < CntFull) && (state_q != StFault);
  assign hs        = cfg_valid && cfg_ready;
  assign flush     = (state_d == StFault);
  assign push      = hs && set_ok && !flush;
  assign in_set    = '{ton: cfg_ton, ts: cfg_ts, id: cfg_id, rpt: cfg_repeat};
  assign head      = mem_q[rd_ptr_q];

  // A set ends either on its repeat count or, for repeat=0, as soon as another set waits.
  assign cnt_inc  = {1'b0, cnt_q} + 17'd1;
  assign set_done = (rpt_q != 16'd0) ? (cnt_inc >= {1'b0, rpt_q}) : (count_q != '0);

  // Next-state, pop decision and latching of the active set.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    ton_d   = ton_q;
    ts_d    = ts_q;
    id_d    = id_q;
    rpt_d   = rpt_q;
    cnt_d   = cnt_q;

    if (fault) begin
      state_d = StFault;
    end else begin
      case (state_q)
        StIdle: begin
          if (enable && (count_q != '0)) begin
            pop     = 1'b1;
            state_d = StRun;
          end
        end
        StRun: begin
          if (!enable) begin
            state_d = StStop;
          end else if (pulse_end) begin
            cnt_d = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
            if (set_done) begin
              if (count_q != '0) begin
                pop = 1'b1;
              end else begin
                state_d = StIdle;
              end
            end
          end
        end
        StStop: begin
          // Enable coming back does not cancel a stop; only the pulse boundary ends it.
          if (pulse_end) begin
            state_d = StIdle;
          end
        end
        StFault: begin
          if (clr_fault) begin
            state_d = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end

    if (pop) begin
      ton_d = head.ton;
      ts_d  = head.ts;
      id_d  = head.id;
      rpt_d = head.rpt;
      cnt_d = 16'd0;
    end
  end

  // Queue pointer and occupancy bookkeeping; a fault flushes everything.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d = ptr_inc(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // Queue storage; contents are only meaningful below the occupancy count.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= in_set;
    end
  end

  // State, queue control and registered drive outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q         <= StIdle;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      count_q         <= '0;
      ton_q           <= 16'd0;
      ts_q            <= 16'd0;
      id_q            <= 16'd0;
      rpt_q           <= 16'd0;
      cnt_q           <= 16'd0;
      power_start_q   <= 1'b0;
      set_active_q    <= 1'b0;
      cfg_err_q       <= 1'b0;
      fault_latched_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      count_q         <= count_d;
      ton_q           <= ton_d;
      ts_q            <= ts_d;
      id_q            <= id_d;
      rpt_q           <= rpt_d;
      cnt_q           <= cnt_d;
      power_start_q   <= (state_d == StRun) || (state_d == StStop);
      set_active_q    <= (state_d == StRun) || (state_d == StStop);
      cfg_err_q       <= hs && !set_ok;
      fault_latched_q <= (state_d == StFault);
    end
  end

  assign power_start   = power_start_q;
  assign set_active    = set_active_q;
  assign Ton           = ton_q;
  assign Ts            = ts_q;
  assign Id_set        = id_q;
  assign pulse_cnt     = cnt_q;
  assign cfg_err       = cfg_err_q;
  assign fault_latched = fault_latched_q;

endmodule

// File: doc/pulse_param_scheduler.md
PULSE_PARAM_SCHEDULER -- requirements
Module: pulse_param_scheduler

Interface
REQ-001 Parameter DEPTH, default 4: entries in the parameter-set queue.
REQ-002 Parameter TS_MIN, default 16'd100: minimum accepted period, in clk cycles.
REQ-003 Parameter DEAD_TIME, default 16'd5: dead-time margin used in set validation.
REQ-004 clk  in  1  50 MHz system clock, the only clock.
REQ-005 rst_n  in  1  reset, synchronous, active-low.
REQ-006 enable  in  1  level; 1 = run queued sets, 0 = graceful stop.
REQ-007 clr_fault  in  1  one-cycle strobe; clears the latched fault.
REQ-008 fault  in  1  level; over-current/danger-short indication.
REQ-009 pulse_end  in  1  one-cycle strobe from buck controller at the T_OFF-to-WAIT_BREAK boundary.
REQ-010 cfg_valid  in  1  host offers a parameter set.
REQ-011 cfg_ready  out  1  queue can accept a set.
REQ-012 cfg_ton, cfg_ts, cfg_id  in  16 each  candidate Ton, Ts and Id_set.
REQ-013 cfg_repeat  in  16  pulses to run with this set; 0 = hold until the next set is queued.
REQ-014 power_start, Ton, Ts, Id_set  out  1/16/16/16  registered drive to the buck controller.
REQ-015 set_active  out  1  a latched set is being applied.
REQ-016 pulse_cnt  out  16  pulses completed with the current set.
REQ-017 cfg_err  out  1  one-cycle strobe; a set was rejected.
REQ-018 fault_latched  out  1  sticky fault indication.

Function
REQ-019 The queue SHALL be a FIFO of DEPTH entries {ton, ts, id, repeat} with an occupancy counter; cfg_ready SHALL be 1 when occupancy < DEPTH and state != FAULT.
REQ-020 A handshake (cfg_valid && cfg_ready) SHALL push the set only when cfg_ts >= TS_MIN and cfg_ton + 2*DEAD_TIME < cfg_ts, both compared in 17-bit arithmetic.
REQ-021 An invalid set SHALL complete the handshake without being pushed, and cfg_err SHALL be 1 on the following cycle for exactly one cycle.
REQ-022 A push and a pop in the same cycle SHALL leave occupancy unchanged; a push SHALL become visible to pop logic only from the next cycle.
REQ-023 FSM states SHALL be IDLE, RUN, STOP and FAULT, with priority fault > !enable > pulse_end.
REQ-024 In IDLE, when enable=1, occupancy>0 and fault=0, the block SHALL pop the head entry, latch ton/ts/id/repeat, set pulse_cnt=0, and go to RUN; power_start and set_active SHALL be 1 from the next cycle.
REQ-025 In RUN, each pulse_end SHALL increment pulse_cnt, saturating at 16'hFFFF.
REQ-026 A set SHALL be finished on a pulse_end when either (a) repeat != 0 and pulse_cnt+1 >= repeat, or (b) repeat == 0 and occupancy > 0.
REQ-027 When a set is finished with occupancy > 0, the block SHALL pop and latch the next set in that same cycle, set pulse_cnt=0, stay in RUN, and keep power_start=1; Ton/Ts/Id_set SHALL change only at this boundary.
REQ-028 When a set is finished with occupancy = 0, the block SHALL go to IDLE, and power_start and set_active SHALL be 0 next cycle.
REQ-029 In RUN with repeat=0 and an empty queue, the block SHALL run indefinitely.
REQ-030 In RUN, enable=0 SHALL move the block to STOP; in STOP, power_start SHALL stay 1 until pulse_end, after which the block goes to IDLE and power_start=0.
REQ-031 In STOP, enable returning to 1 SHALL NOT cancel the stop.
REQ-032 fault=1 in any state SHALL move the block to FAULT next cycle: power_start=0, set_active=0, queue flushed (occupancy=0), fault_latched=1.
REQ-033 FAULT SHALL exit to IDLE only on clr_fault=1 with fault=0 in the same cycle; fault_latched SHALL then clear.
REQ-034 Ton/Ts/Id_set SHALL hold their last latched values in IDLE, STOP and FAULT.

Reset
REQ-035 On rst_n=0 at a clk edge: state=IDLE; occupancy=0; power_start, set_active, cfg_err and fault_latched=0; Ton=Ts=Id_set=pulse_cnt=0; cfg_ready=1 in the first cycle after reset release.
REQ-036 A reset asserted mid-RUN SHALL drop power_start on the same edge and discard all queued sets.

Verification
REQ-037 Push {ton=100, ts=400, id=800, rep=3}, enable=1, three pulse_end strobes -> power_start=1 one cycle after pop, pulse_cnt 1,2,3, then IDLE and power_start=0.
REQ-038 Queue set A (rep=2) and set B (ts=600, rep=0); after 2 pulse_end -> Ts changes 400->600 on the boundary cycle with power_start held 1; B then runs indefinitely until set C is queued and the next pulse_end pops C.
REQ-039 Offer cfg_ts=90, then cfg_ton=395 with cfg_ts=400 -> both rejected, cfg_err strobed once per set, occupancy stays 0.
REQ-040 Push 5 sets with no pops -> cfg_ready=0 after the 4th; the 5th is held until a pop, after which it is accepted.
REQ-041 fault=1 mid-RUN with 2 sets queued -> power_start=0 next cycle, occupancy=0; clr_fault while fault=1 is ignored; clr_fault with fault=0 -> IDLE.
REQ-042 Drop enable mid-pulse -> state STOP, power_start held 1 until pulse_end, then 0; raising enable during STOP does not cancel the stop.
